// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default operand widths and the bit-counter width rule.
package divider_pkg;

  localparam int DVD_W_DEF = 8;
  localparam int DVS_W_DEF = 4;

  // One spare bit so the counter can reach DVD_W without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int CNT_W = cnt_width(DVD_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ZERO = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it is non-negative.
module div_step #(
  parameter int DVS_W = 4
) (
  input  logic [DVS_W:0]   rem,
  input  logic             bit_in,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W:0]   rem_next,
  output logic             q_bit
);

  logic [DVS_W:0]          shifted;
  logic signed [DVS_W+1:0] trial;

  assign shifted = {rem[DVS_W-1:0], bit_in};
  assign trial   = $signed({1'b0, shifted}) - $signed({2'b00, divisor});

  // A set top bit in rem would already exceed any divisor after the shift.
  assign q_bit    = rem[DVS_W] | ~trial[DVS_W+1];
  assign rem_next = q_bit ? trial[DVS_W:0] : shifted;

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider producing one quotient bit per clock behind a
// start/busy/done handshake; divide-by-zero takes a one-cycle ZERO path.
module seq_restoring_divider
  import divider_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             dbz
);

  localparam int            CW   = cnt_width(DVD_W);
  localparam logic [CW-1:0] LAST = CW'(DVD_W - 1);

  state_t state, state_nxt;
  logic   load, step, finish, zero_fin;

  logic [CW-1:0]    cnt;
  logic [DVD_W-1:0] dvd_sr;
  logic [DVS_W-1:0] dvs;
  logic [DVS_W:0]   rem, rem_nxt;
  logic             q_bit;

  div_step #(.DVS_W(DVS_W)) u_step (
    .rem      (rem),
    .bit_in   (dvd_sr[DVD_W-1]),
    .divisor  (dvs),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    zero_fin  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            load      = 1'b1;
            state_nxt = BUSY;
          end else begin
            state_nxt = ZERO;
          end
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      ZERO: begin
        zero_fin  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Quotient bits shift into the vacated low end of the dividend register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      dvd_sr    <= '0;
      dvs       <= '0;
      rem       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= finish | zero_fin;
      if (load) begin
        dvd_sr <= dividend;
        dvs    <= divisor;
        rem    <= '0;
        cnt    <= '0;
      end
      if (step) begin
        dvd_sr <= {dvd_sr[DVD_W-2:0], q_bit};
        rem    <= rem_nxt;
        cnt    <= cnt + CW'(1);
      end
      if (finish) begin
        quotient  <= {dvd_sr[DVD_W-2:0], q_bit};
        remainder <= rem_nxt[DVS_W-1:0];
        dbz       <= 1'b0;
      end
      if (zero_fin) begin
        quotient  <= '1;
        remainder <= '0;
        dbz       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed cases, random operands with
// start/operand noise during BUSY, mid-operation reset and an exhaustive sweep.
module tb_seq_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       dbz;

  int total = 0;
  int bad   = 0;

  seq_restoring_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts an operation from a falling edge and returns on the falling edge
  // where done is seen (start already low), so a following call is back-to-back.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input bit noise,
                        input string tag);
    int  lat, bcnt;
    bit  seen, overlap;
    int  exp_q, exp_r, exp_d, exp_lat;
    if (b == 0) begin
      exp_q = 255; exp_r = 0; exp_d = 1; exp_lat = 1;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_d = 0; exp_lat = 8;
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    lat = 0; bcnt = 0; seen = 0; overlap = 0;
    @(negedge clk);
    start = noise;
    while (!seen && lat < 20) begin
      if (busy && done) overlap = 1;
      if (done) begin
        seen  = 1;
        start = 1'b0;
      end else begin
        if (busy) bcnt++;
        if (noise) begin
          dividend = 8'($urandom);
          divisor  = 4'($urandom);
        end
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk({tag, ".lat"},  lat,       exp_lat);
    chk({tag, ".busy"}, bcnt,      exp_lat);
    chk({tag, ".ovl"},  overlap,   0);
    chk({tag, ".q"},    quotient,  exp_q);
    chk({tag, ".r"},    remainder, exp_r);
    chk({tag, ".dbz"},  dbz,       exp_d);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.q",    quotient, 0);
    chk("rst.r",    remainder, 0);
    chk("rst.dbz",  dbz, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'd200, 4'd7,  0, "d200_7");
    run_op(8'd255, 4'd1,  0, "d255_1");
    run_op(8'd5,   4'd9,  0, "d5_9");
    run_op(8'd0,   4'd15, 0, "d0_15");
    run_op(8'd255, 4'd15, 0, "d255_15");
    run_op(8'd100, 4'd0,  0, "d100_0");
    run_op(8'd100, 4'd3,  0, "d100_3");
    run_op(8'd200, 4'd7,  1, "noise200_7");
    run_op(8'd77,  4'd6,  0, "b2b77_6");

    // Results must hold with no new done while idle.
    repeat (3) @(negedge clk);
    chk("hold.done", done, 0);
    chk("hold.q",    quotient, 12);
    chk("hold.r",    remainder, 5);

    // Reset during an operation aborts it immediately.
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.busy", busy, 0);
    chk("arst.done", done, 0);
    chk("arst.q",    quotient, 0);
    chk("arst.r",    remainder, 0);
    chk("arst.dbz",  dbz, 0);
    begin
      bit any_done = 0;
      repeat (3) begin
        @(negedge clk);
        if (done) any_done = 1;
      end
      rst_n = 1'b1;
      repeat (6) begin
        @(negedge clk);
        if (done) any_done = 1;
      end
      chk("arst.nodone", any_done, 0);
    end
    run_op(8'd200, 4'd7, 0, "after_rst");

    for (int i = 0; i < 300; i++)
      run_op(8'($urandom), 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), "rand");

    for (int b = 0; b < 16; b++)
      for (int a = 0; a < 256; a++)
        run_op(8'(a), 4'(b), 0, "exh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
